wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 55 +++++
 rtl/wb_arbiter.sv | 116 +++++++++++
 tb/tb_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// ============================================================================
// Module   : wb_arbiter_if
// Brief    : Issue, writeback-request and register-file bundle for wb_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_arbiter_if;
    // Decode / issue side
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        iss_stall;

    // Writeback requesters
    logic        alu_req;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_gnt;
    logic        lsu_req;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_gnt;

    // Register-file write port, forwarding and status
    logic        regwen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        byp1_hit;
    logic        byp2_hit;
    logic [31:0] byp_data;
    logic [31:0] busy;
    logic        err;

    modport master (
        output iss_valid, iss_rd, iss_rs1, iss_rs2,
        output alu_req, alu_waddr, alu_wdata,
        output lsu_req, lsu_waddr, lsu_wdata,
        input  iss_stall, alu_gnt, lsu_gnt,
        input  regwen, waddr, wdata,
        input  byp1_hit, byp2_hit, byp_data, busy, err
    );

    modport slave (
        input  iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  alu_req, alu_waddr, alu_wdata,
        input  lsu_req, lsu_waddr, lsu_wdata,
        output iss_stall, alu_gnt, lsu_gnt,
        output regwen, waddr, wdata,
        output byp1_hit, byp2_hit, byp_data, busy, err
    );
endinterface : wb_arbiter_if

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Round-robin ALU/LSU writeback arbiter with register scoreboard.
//            Optional forwarding of the in-flight write: define WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam logic [31:0] C_ONE = 32'd1;

    logic        r_prio;
    logic        r_err;
    logic        r_regwen;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_busy;

    logic        w_alu_gnt;
    logic        w_lsu_gnt;
    logic        w_gnt;
    logic        w_contest;
    logic [4:0]  w_gnt_addr;
    logic [31:0] w_gnt_data;
    logic        w_byp1;
    logic        w_byp2;
    logic [31:0] w_byp_data;
    logic        w_rs1_blk;
    logic        w_rs2_blk;
    logic        w_rd_blk;
    logic        w_stall;
    logic        w_issue;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_busy_nxt;
    logic        w_err_hit;

    // prio=0 lets the ALU win a contested cycle, prio=1 lets the LSU win.
    assign w_contest  = bus.alu_req & bus.lsu_req;
    assign w_alu_gnt  = bus.alu_req & ~(bus.lsu_req & r_prio);
    assign w_lsu_gnt  = bus.lsu_req & ~(bus.alu_req & ~r_prio);
    assign w_gnt      = w_alu_gnt | w_lsu_gnt;
    assign w_gnt_addr = w_lsu_gnt ? bus.lsu_waddr : bus.alu_waddr;
    assign w_gnt_data = w_lsu_gnt ? bus.lsu_wdata : bus.alu_wdata;

`ifdef WB_BYPASS_EN
    // r_regwen already implies r_waddr != 0, so x0 can never hit.
    assign w_byp1     = r_regwen & (r_waddr == bus.iss_rs1);
    assign w_byp2     = r_regwen & (r_waddr == bus.iss_rs2);
    assign w_byp_data = r_wdata;
`else
    assign w_byp1     = 1'b0;
    assign w_byp2     = 1'b0;
    assign w_byp_data = 32'd0;
`endif

    // Destination is never forwarded: a pending rd always blocks issue.
    assign w_rs1_blk  = r_busy[bus.iss_rs1] & ~w_byp1;
    assign w_rs2_blk  = r_busy[bus.iss_rs2] & ~w_byp2;
    assign w_rd_blk   = r_busy[bus.iss_rd];
    assign w_stall    = bus.iss_valid & (w_rs1_blk | w_rs2_blk | w_rd_blk);
    assign w_issue    = bus.iss_valid & ~w_stall & (bus.iss_rd != 5'd0);

    assign w_set_mask = w_issue  ? (C_ONE << bus.iss_rd) : 32'd0;
    assign w_clr_mask = r_regwen ? (C_ONE << r_waddr)    : 32'd0;
    // OR-ing the set after the clear lets a same-edge issue win over retire.
    assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~C_ONE;

    assign w_err_hit  = w_gnt & (w_gnt_addr != 5'd0) & ~r_busy[w_gnt_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio   <= 1'b0;
            r_err    <= 1'b0;
            r_regwen <= 1'b0;
            r_waddr  <= 5'd0;
            r_wdata  <= 32'd0;
            r_busy   <= 32'd0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_err_hit) begin
                r_err <= 1'b1;
            end
            if (w_contest) begin
                r_prio <= w_alu_gnt;
            end
            if (w_gnt) begin
                r_regwen <= (w_gnt_addr != 5'd0);
                r_waddr  <= w_gnt_addr;
                r_wdata  <= w_gnt_data;
            end else begin
                r_regwen <= 1'b0;
            end
        end
    end

    assign bus.iss_stall = w_stall;
    assign bus.alu_gnt   = w_alu_gnt;
    assign bus.lsu_gnt   = w_lsu_gnt;
    assign bus.regwen    = r_regwen;
    assign bus.waddr     = r_waddr;
    assign bus.wdata     = r_wdata;
    assign bus.byp1_hit  = w_byp1;
    assign bus.byp2_hit  = w_byp2;
    assign bus.byp_data  = w_byp_data;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule : wb_arbiter

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Scenario bench for wb_arbiter with a write-port scoreboard queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {regwen, waddr, wdata} after each edge.
    logic [37:0] exp_q[$];
    logic [37:0] e;

    logic [31:0] m_busy   = 32'd0;
    logic        m_prio   = 1'b0;
    logic        m_err    = 1'b0;
    logic        m_regwen = 1'b0;
    logic [4:0]  m_waddr  = 5'd0;
    logic [31:0] m_wdata  = 32'd0;

`ifdef WB_BYPASS_EN
    localparam logic C_BYP = 1'b1;
`else
    localparam logic C_BYP = 1'b0;
`endif

    function automatic logic src_blk(input logic [4:0] idx);
        logic b;
        b = m_busy[idx];
        if (C_BYP && m_regwen && (m_waddr == idx)) b = 1'b0;
        return b;
    endfunction

    task automatic clear_inputs();
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
        bus.alu_req = 1'b0; bus.alu_waddr = 5'd0; bus.alu_wdata = 32'd0;
        bus.lsu_req = 1'b0; bus.lsu_waddr = 5'd0; bus.lsu_wdata = 32'd0;
    endtask

    // Advances one clock and updates the reference model from the inputs
    // that were presented during the cycle.
    task automatic tick();
        logic ag, lg, st, r;
        logic [4:0]  ga;
        logic [31:0] gd, nb;
        r  = rst;
        ag = bus.alu_req & (~bus.lsu_req | ~m_prio);
        lg = bus.lsu_req & (~bus.alu_req | m_prio);
        ga = lg ? bus.lsu_waddr : bus.alu_waddr;
        gd = lg ? bus.lsu_wdata : bus.alu_wdata;
        st = bus.iss_valid & (src_blk(bus.iss_rs1) | src_blk(bus.iss_rs2) | m_busy[bus.iss_rd]);
        nb = m_busy;
        if (m_regwen) nb[m_waddr] = 1'b0;
        if (bus.iss_valid && !st && bus.iss_rd != 5'd0) nb[bus.iss_rd] = 1'b1;
        nb[0] = 1'b0;
        @(posedge clk);
        if (r) begin
            m_busy = 32'd0; m_prio = 1'b0; m_err = 1'b0;
            m_regwen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
        end else begin
            if ((ag | lg) && ga != 5'd0 && !m_busy[ga]) m_err = 1'b1;
            if (bus.alu_req && bus.lsu_req) m_prio = ag;
            m_busy = nb;
            if (ag | lg) begin
                m_regwen = (ga != 5'd0); m_waddr = ga; m_wdata = gd;
            end else begin
                m_regwen = 1'b0;
            end
        end
        exp_q.push_back({m_regwen, m_waddr, m_wdata});
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL reset_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        end
        rst = 1'b0;
        n_checks++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    endtask

    task automatic test_issue_and_write();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL issue_rd5_stall: got %b want 0", bus.iss_stall); end
        tick();
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL issue_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if (bus.busy !== 32'h0000_0020) begin n_fail++; $display("FAIL busy5_set: got %h want 00000020", bus.busy); end

        bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd5;
        bus.alu_req = 1'b1; bus.alu_waddr = 5'd5; bus.alu_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", bus.iss_stall); end
        n_checks++; if ({bus.alu_gnt, bus.lsu_gnt} !== 2'b10) begin n_fail++; $display("FAIL alu_only_gnt: got %b want 10", {bus.alu_gnt, bus.lsu_gnt}); end
        tick();
        bus.alu_req = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL alu_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL alu_write_deadbeef: got %h", {bus.regwen, bus.waddr, bus.wdata}); end
        #1;
        n_checks++; if (bus.iss_stall !== ~C_BYP) begin n_fail++; $display("FAIL stall_during_write: got %b want %b", bus.iss_stall, ~C_BYP); end
        n_checks++; if (bus.byp1_hit !== C_BYP) begin n_fail++; $display("FAIL byp1_hit: got %b want %b", bus.byp1_hit, C_BYP); end
        n_checks++; if (bus.busy !== 32'h0000_0020) begin n_fail++; $display("FAIL busy5_held: got %h want 00000020", bus.busy); end
        tick();
        bus.iss_valid = 1'b0; bus.iss_rs1 = 5'd0;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL idle_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL busy5_clr: got %h want 0", bus.busy); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_after_legal: got %b want 0", bus.err); end
    endtask

    task automatic test_round_robin();
        logic exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        clear_inputs();
        for (int r = 1; r <= 4; r++) begin
            bus.iss_valid = 1'b1; bus.iss_rd = 5'(r);
            tick();
            e = exp_q.pop_front();
            n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL rr_issue_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        end
        bus.iss_valid = 1'b0;
        n_checks++; if (bus.busy !== 32'h0000_001E) begin n_fail++; $display("FAIL rr_busy: got %h want 0000001e", bus.busy); end
        bus.alu_req = 1'b1; bus.alu_waddr = 5'd1; bus.alu_wdata = 32'hA000_0001;
        bus.lsu_req = 1'b1; bus.lsu_waddr = 5'd2; bus.lsu_wdata = 32'hB000_0002;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if ({bus.alu_gnt, bus.lsu_gnt} !== {exp_alu[k], ~exp_alu[k]}) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, {bus.alu_gnt, bus.lsu_gnt}, {exp_alu[k], ~exp_alu[k]}); end
            tick();
            if (exp_alu[k]) begin bus.alu_waddr = 5'd3; bus.alu_wdata = 32'hA000_0003; end
            else            begin bus.lsu_waddr = 5'd4; bus.lsu_wdata = 32'hB000_0004; end
            e = exp_q.pop_front();
            n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL rr_wport[%0d]: got %h want %h", k, {bus.regwen, bus.waddr, bus.wdata}, e); end
        end
        clear_inputs();
        tick();
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL rr_drain_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL rr_busy_drained: got %h want 0", bus.busy); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b want 0", bus.err); end
    endtask

    task automatic test_reg0_err_setwins();
        bus.lsu_req = 1'b1; bus.lsu_waddr = 5'd0; bus.lsu_wdata = 32'h0000_1234;
        #1;
        n_checks++; if ({bus.alu_gnt, bus.lsu_gnt} !== 2'b01) begin n_fail++; $display("FAIL reg0_gnt: got %b want 01", {bus.alu_gnt, bus.lsu_gnt}); end
        tick();
        bus.lsu_req = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL reg0_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if ({bus.regwen, bus.err, bus.busy} !== 34'd0) begin n_fail++; $display("FAIL reg0_effects: regwen %b err %b busy %h want all 0", bus.regwen, bus.err, bus.busy); end

        bus.alu_req = 1'b1; bus.alu_waddr = 5'd9; bus.alu_wdata = 32'h0000_0099;
        tick();
        bus.alu_waddr = 5'd7; bus.alu_wdata = 32'h0000_0077;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL err9_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", bus.err); end
        tick();
        bus.alu_req = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL w7_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        #1;
        n_checks++; if (bus.iss_stall !== 1'b0) begin n_fail++; $display("FAIL rd7_stall: got %b want 0", bus.iss_stall); end
        tick();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL setwins_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if (bus.busy !== 32'h0000_0080) begin n_fail++; $display("FAIL set_wins_busy7: got %h want 00000080", bus.busy); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    endtask

    task automatic test_bypass();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        tick();
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
        bus.alu_req = 1'b1; bus.alu_waddr = 5'd3; bus.alu_wdata = 32'h0000_0055;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL byp_issue_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        tick();
        bus.alu_req = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL byp_write_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        bus.iss_valid = 1'b1; bus.iss_rs2 = 5'd3;
        #1;
        n_checks++; if (bus.iss_stall !== ~C_BYP) begin n_fail++; $display("FAIL byp_stall: got %b want %b", bus.iss_stall, ~C_BYP); end
        n_checks++; if ({bus.byp1_hit, bus.byp2_hit} !== {1'b0, C_BYP}) begin n_fail++; $display("FAIL byp_hits: got %b want %b", {bus.byp1_hit, bus.byp2_hit}, {1'b0, C_BYP}); end
        n_checks++; if (bus.byp_data !== (C_BYP ? 32'h0000_0055 : 32'd0)) begin n_fail++; $display("FAIL byp_data: got %h want %h", bus.byp_data, (C_BYP ? 32'h0000_0055 : 32'd0)); end
        tick();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL byp_after_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
    endtask

    task automatic test_reset_mid();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        tick();
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL rm_issue_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        bus.alu_req = 1'b1; bus.alu_waddr = 5'd4; bus.alu_wdata = 32'h0000_0044;
        bus.lsu_req = 1'b1; bus.lsu_waddr = 5'd7; bus.lsu_wdata = 32'h0000_0070;
        #1;
        n_checks++; if ({bus.alu_gnt, bus.lsu_gnt} !== 2'b10) begin n_fail++; $display("FAIL rm_contest_gnt: got %b want 10", {bus.alu_gnt, bus.lsu_gnt}); end
        tick();
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL rm_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        rst = 1'b1;
        #1;
        n_checks++; if ({bus.alu_gnt, bus.lsu_gnt} !== 2'b01) begin n_fail++; $display("FAIL rm_gnt_in_reset: got %b want 01", {bus.alu_gnt, bus.lsu_gnt}); end
        tick();
        rst = 1'b0;
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL rm_reset_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if ({bus.busy, bus.regwen, bus.err} !== 34'd0) begin n_fail++; $display("FAIL rm_state: busy %h regwen %b err %b want all 0", bus.busy, bus.regwen, bus.err); end
        #1;
        n_checks++; if ({bus.alu_gnt, bus.lsu_gnt} !== 2'b10) begin n_fail++; $display("FAIL rm_prio_reset: got %b want 10", {bus.alu_gnt, bus.lsu_gnt}); end
        tick();
        clear_inputs();
        e = exp_q.pop_front();
        n_checks++; if ({bus.regwen, bus.waddr, bus.wdata} !== e) begin n_fail++; $display("FAIL rm_post_wport: got %h want %h", {bus.regwen, bus.waddr, bus.wdata}, e); end
        n_checks++; if (bus.err !== m_err) begin n_fail++; $display("FAIL rm_post_err: got %b want %b", bus.err, m_err); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_issue_and_write();
        test_round_robin();
        test_reg0_err_setwins();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_wb_arbiter

`default_nettype wire
